// File: rtl/sync_ram_waitstate_if.sv
// Request/response bus between a memory master and sync_ram_waitstate.
// The master drives the request fields; the RAM drives ready and the completion pulses.
interface sync_ram_waitstate_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8
);
    logic                             req;
    logic                             we;
    logic [ADDR_WIDTH-1:0]            addr;
    logic [DATA_WIDTH-1:0]            wdata;
    logic [DATA_WIDTH/BYTE_WIDTH-1:0] be;
    logic                             ready;
    logic                             rvalid;
    logic                             wack;
    logic [DATA_WIDTH-1:0]            rdata;
    logic                             err;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rvalid, wack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rvalid, wack, rdata, err
    );
endinterface

// File: rtl/sync_ram_waitstate.sv
// Single-port synchronous RAM with req/ready handshake, programmable wait states,
// byte-enable writes, completion pulses, out-of-range error and optional zero-fill sweep.
module sync_ram_waitstate #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned LENGTH         = 1 << ADDR_WIDTH,
    parameter int unsigned WAIT_STATES    = 2,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    sync_ram_waitstate_if.slave bus
);
    localparam int unsigned NBytes   = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned IdxWidth = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam bit          NoWait   = (WAIT_STATES == 0);
    localparam logic [3:0]  WaitCnt  = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH:0] LengthW  = (ADDR_WIDTH + 1)'(LENGTH);
    localparam logic [ADDR_WIDTH:0] LastWord = (ADDR_WIDTH + 1)'(LENGTH - 1);

    typedef enum logic [1:0] {StClear, StIdle, StWait} state_e;
    localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StIdle;

    state_e state_q, state_d;

    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH:0]     clr_ptr_q;
    logic                    lat_we_q;
    logic [ADDR_WIDTH-1:0]   lat_addr_q;
    logic [DATA_WIDTH-1:0]   lat_wdata_q;
    logic [NBytes-1:0]       lat_be_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rvalid_q;
    logic                    wack_q;
    logic                    err_q;

    logic                    ready;
    logic                    accept;
    logic                    fire;
    logic                    clear_en;
    logic                    acc_we;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic [NBytes-1:0]       acc_be;
    logic                    in_range;
    logic [IdxWidth-1:0]     acc_idx;
    logic [IdxWidth-1:0]     clr_idx;

    logic [DATA_WIDTH-1:0]   mem [LENGTH];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ResetState;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: if (clr_ptr_q == LastWord) state_d = StIdle;
            StIdle:  if (accept && !NoWait) state_d = StWait;
            StWait:  if (cnt_q == 4'd1) state_d = StIdle;
            default: state_d = ResetState;
        endcase
    end

    // Outputs: zero-wait accesses use the live bus fields, delayed ones the latched copy.
    always_comb begin
        ready     = 1'b0;
        fire      = 1'b0;
        clear_en  = 1'b0;
        acc_we    = lat_we_q;
        acc_addr  = lat_addr_q;
        acc_wdata = lat_wdata_q;
        acc_be    = lat_be_q;
        unique case (state_q)
            StClear: clear_en = 1'b1;
            StIdle: begin
                ready = 1'b1;
                if (bus.req && NoWait) begin
                    fire      = 1'b1;
                    acc_we    = bus.we;
                    acc_addr  = bus.addr;
                    acc_wdata = bus.wdata;
                    acc_be    = bus.be;
                end
            end
            StWait:  fire = (cnt_q == 4'd1);
            default: ;
        endcase
    end

    assign accept   = ready & bus.req;
    assign in_range = {1'b0, acc_addr} < LengthW;
    assign acc_idx  = acc_addr[IdxWidth-1:0];
    assign clr_idx  = clr_ptr_q[IdxWidth-1:0];

    // Storage is never reset; only the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (clear_en) begin
            mem[clr_idx] <= '0;
        end else if (fire && acc_we && in_range) begin
            for (int i = 0; i < int'(NBytes); i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        acc_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            clr_ptr_q   <= '0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_be_q    <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            wack_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rvalid_q <= fire & ~acc_we;
            wack_q   <= fire & acc_we;
            err_q    <= fire & ~in_range;
            if (fire && !acc_we) begin
                rdata_q <= in_range ? mem[acc_idx] : '0;
            end
            if (clear_en) begin
                clr_ptr_q <= clr_ptr_q + (ADDR_WIDTH + 1)'(1);
            end
            if (accept) begin
                lat_we_q    <= bus.we;
                lat_addr_q  <= bus.addr;
                lat_wdata_q <= bus.wdata;
                lat_be_q    <= bus.be;
                cnt_q       <= WaitCnt;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign bus.ready  = ready;
    assign bus.rvalid = rvalid_q;
    assign bus.wack   = wack_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_sync_ram_waitstate.sv
// Bench for sync_ram_waitstate: three instances (N=2 with clear, N=0 without clear,
// N=2 without clear) share one stimulus path; a word-array model predicts every response.
module tb_sync_ram_waitstate;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic        req, we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic        ready_m, rvalid_m, wack_m, err_m;
    logic [31:0] rdata_m;

    int n_cmp = 0;
    int n_err = 0;

    // Model: wait states and clear behaviour per instance, word contents, last read data
    int          ws      [3] = '{2, 0, 2};
    bit          clr_on  [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] model   [3][16];
    logic [31:0] last_rd [3];

    always #5 clk = ~clk;

    sync_ram_waitstate_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if0 ();
    sync_ram_waitstate_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if1 ();
    sync_ram_waitstate_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if2 ();

    assign if0.req = req && (sel == 2'd0);
    assign if1.req = req && (sel == 2'd1);
    assign if2.req = req && (sel == 2'd2);
    assign if0.we = we;       assign if1.we = we;       assign if2.we = we;
    assign if0.addr = addr;   assign if1.addr = addr;   assign if2.addr = addr;
    assign if0.wdata = wdata; assign if1.wdata = wdata; assign if2.wdata = wdata;
    assign if0.be = be;       assign if1.be = be;       assign if2.be = be;

    sync_ram_waitstate #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WIDTH(8), .LENGTH(16),
        .WAIT_STATES(2), .CLEAR_ON_RESET(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    sync_ram_waitstate #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WIDTH(8), .LENGTH(16),
        .WAIT_STATES(0), .CLEAR_ON_RESET(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    sync_ram_waitstate #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WIDTH(8), .LENGTH(16),
        .WAIT_STATES(2), .CLEAR_ON_RESET(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    always_comb begin
        ready_m = if0.ready; rvalid_m = if0.rvalid; wack_m = if0.wack;
        err_m = if0.err; rdata_m = if0.rdata;
        if (sel == 2'd1) begin
            ready_m = if1.ready; rvalid_m = if1.rvalid; wack_m = if1.wack;
            err_m = if1.err; rdata_m = if1.rdata;
        end else if (sel == 2'd2) begin
            ready_m = if2.ready; rvalid_m = if2.rvalid; wack_m = if2.wack;
            err_m = if2.err; rdata_m = if2.rdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] b);
        logic [31:0] mask;
        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    // Counts cycles with ready low after reset release; a clearing instance needs 16.
    task automatic wait_clear();
        int c;
        c = 0;
        while (!ready_m && c < 100) begin
            c++;
            @(negedge clk);
        end
        chk("clear_cycles", 32'(c), 32'd16);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 16; i++) if (clr_on[0]) model[0][i] = '0;
        for (int s = 0; s < 3; s++) last_rd[s] = '0;
    endtask

    // One complete handshake on the selected instance with latency and response checks.
    task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] b);
        int          guard;
        int          lat;
        logic        oor;
        logic [31:0] exp_rd;
        oor = (a >= 8'd16);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        #1;
        guard = 0;
        while (!ready_m && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("accept_bound", 32'(guard < 100), 32'd1);
        @(negedge clk);
        req = 1'b0;
        lat = 0;
        while (!(rvalid_m || wack_m) && lat < 40) begin
            chk("busy_ready", 32'(ready_m), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(ws[sel]));
        chk("pulse_kind", 32'({rvalid_m, wack_m}), w ? 32'd1 : 32'd2);
        chk("err", 32'(err_m), 32'(oor));
        chk("ready_after", 32'(ready_m), 32'd1);
        if (w) begin
            if (!oor) model[sel][a[3:0]] = merge(model[sel][a[3:0]], d, b);
            chk("rdata_hold", rdata_m, last_rd[sel]);
        end else begin
            exp_rd = oor ? 32'd0 : model[sel][a[3:0]];
            chk("rdata", rdata_m, exp_rd);
            last_rd[sel] = exp_rd;
        end
        @(negedge clk);
        chk("pulse_once", 32'({rvalid_m, wack_m, err_m}), 32'd0);
    endtask

    // Reset arrives one cycle after a write to addr 2 is accepted; the write must vanish.
    task automatic mid_reset();
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 8'd2; wdata = 32'h55; be = 4'hF;
        #1;
        chk("mr_ready_pre", 32'(ready_m), 32'd1);
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr_ready_rst", 32'(ready_m), clr_on[sel] ? 32'd0 : 32'd1);
        chk("mr_no_wack", 32'(wack_m), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("mr_no_wack_rst", 32'(wack_m), 32'd0);
        end
        rst = 1'b0;
        reset_model();
        if (clr_on[sel]) wait_clear();
        repeat (3) begin
            @(negedge clk);
            chk("mr_no_wack_post", 32'(wack_m), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; sel = 2'd0;
        for (int s = 0; s < 3; s++) for (int i = 0; i < 16; i++) model[s][i] = '0;
        reset_model();
        repeat (3) @(negedge clk);

        // Reset state of every instance
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk("rst_ready", 32'(ready_m), clr_on[s] ? 32'd0 : 32'd1);
            chk("rst_pulses", 32'({rvalid_m, wack_m, err_m}), 32'd0);
            chk("rst_rdata", rdata_m, 32'd0);
        end

        // Clear sweep then read every word back as zero
        sel = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        wait_clear();
        for (int i = 0; i < 16; i++) access(1'b0, 8'(i), 32'd0, 4'h0);

        // Full write/read with two wait states
        access(1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
        access(1'b0, 8'd5, 32'd0, 4'h0);

        // Byte-lane merge and be=0 no-op write
        access(1'b1, 8'd7, 32'h11223344, 4'hF);
        access(1'b1, 8'd7, 32'hAABBCCDD, 4'b0101);
        access(1'b0, 8'd7, 32'd0, 4'h0);
        chk("be_merge_word", rdata_m, 32'h11BB33DD);
        access(1'b1, 8'd7, $urandom, 4'h0);
        access(1'b0, 8'd7, 32'd0, 4'h0);
        chk("be_zero_word", rdata_m, 32'h11BB33DD);

        // Out-of-range accesses must not alias onto addr 4
        access(1'b1, 8'd4, 32'hCAFE0004, 4'hF);
        access(1'b1, 8'd20, 32'h12345678, 4'hF);
        access(1'b0, 8'd20, 32'd0, 4'h0);
        access(1'b0, 8'd4, 32'd0, 4'h0);
        chk("oor_no_alias", rdata_m, 32'hCAFE0004);

        for (int k = 0; k < 30; k++)
            access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), $urandom, 4'($urandom));

        // Zero-wait instance: initialise, back-to-back write/read, then random
        sel = 2'd1;
        for (int i = 0; i < 16; i++) access(1'b1, 8'(i), $urandom, 4'hF);
        @(negedge clk);
        v = $urandom;
        req = 1'b1; we = 1'b1; addr = 8'd3; wdata = v; be = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(ready_m), 32'd1);
            if (we) begin
                chk("b2b_wack", 32'(wack_m), 32'd1);
                model[1][3] = wdata;
                we = 1'b0;
            end else begin
                chk("b2b_rvalid", 32'(rvalid_m), 32'd1);
                chk("b2b_rdata", rdata_m, model[1][3]);
                last_rd[1] = model[1][3];
                we = 1'b1;
                wdata = $urandom;
            end
        end
        req = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 30; k++)
            access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), $urandom, 4'($urandom));

        // Reset during a pending write, clearing instance first
        sel = 2'd0;
        access(1'b1, 8'd2, 32'hA5A50002, 4'hF);
        mid_reset();
        access(1'b0, 8'd2, 32'd0, 4'h0);

        // Same on the non-clearing instance: prior value must survive
        sel = 2'd2;
        for (int i = 0; i < 16; i++) access(1'b1, 8'(i), $urandom, 4'hF);
        access(1'b1, 8'd2, 32'h0BADF00D, 4'hF);
        mid_reset();
        access(1'b0, 8'd2, 32'd0, 4'h0);
        chk("mr_prior_value", rdata_m, 32'h0BADF00D);

        // Zero-wait instance kept its contents across both resets
        sel = 2'd1;
        for (int i = 0; i < 16; i += 5) access(1'b0, 8'(i), 32'd0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
